// File: rtl/axis_cobs_frame_encoder.sv
// axis_cobs_frame_encoder
//   Serialises the kept bytes of a byte-keyed AXI-Stream into single bytes and
//   COBS-encodes each tlast-terminated frame. The output is an 8-bit AXI-Stream
//   with an optional 0x00 frame delimiter.
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   s_axis_*            input words (tdata/tkeep/tvalid/tready/tlast), byte 0 first
//   m_axis_*            encoded byte stream (tdata/tvalid/tready/tlast)
//   busy                high from the first accepted word until the frame's last byte handshakes
//   frame_count         number of frames fully emitted (wraps)
module axis_cobs_frame_encoder #(
    parameter int unsigned DATA_BYTES       = 6,
    parameter int unsigned MAX_RUN          = 254,
    parameter bit          APPEND_DELIMITER = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic [15:0]             frame_count
);

    localparam int unsigned DW = 8 * DATA_BYTES;
    localparam int unsigned SW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int unsigned NW = $clog2(MAX_RUN + 1);

    typedef enum logic [1:0] {FILL, EMIT_CODE, EMIT_DATA, DELIM} state_t;
    // What follows once the current block has been emitted.
    typedef enum logic [1:0] {AFT_FILL, AFT_CODE1, AFT_DELIM} after_t;

    state_t          state, state_d;
    after_t          after, after_d;
    logic [DW-1:0]   word_data, word_data_d;
    logic [DATA_BYTES-1:0] word_keep, word_keep_d;
    logic            word_last, word_last_d;
    logic            word_valid, word_valid_d;
    logic [NW-1:0]   run_n, run_n_d;
    logic [NW-1:0]   idx, idx_d;
    logic [7:0]      out_data_d;
    logic            out_valid_d, out_last_d;
    logic            tready_d, busy_d;
    logic [15:0]     fcount_d;

    logic [7:0]      blk_mem [MAX_RUN];
    logic            blk_we;

    logic [SW-1:0]   sel;
    logic [7:0]      cur_byte;
    logic [DATA_BYTES-1:0] keep_rem;
    logic            byte_last;

    logic            close, next_block;
    logic [NW-1:0]   close_n;
    after_t          close_after;
    logic [NW-1:0]   nxt_idx;

    logic            in_fire, out_fire;

    assign in_fire  = s_axis_tvalid && s_axis_tready;
    assign out_fire = m_axis_tvalid && m_axis_tready;

    // Lowest remaining kept byte of the held word.
    always_comb begin
        sel = '0;
        for (int i = int'(DATA_BYTES) - 1; i >= 0; i--) begin
            if (word_keep[i]) sel = SW'(i);
        end
        cur_byte  = word_data[8*int'(sel) +: 8];
        keep_rem  = word_keep & ~(DATA_BYTES'(1) << sel);
        byte_last = word_last && (keep_rem == '0);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state;
        after_d      = after;
        word_data_d  = word_data;
        word_keep_d  = word_keep;
        word_last_d  = word_last;
        word_valid_d = word_valid;
        run_n_d      = run_n;
        idx_d        = idx;
        out_data_d   = m_axis_tdata;
        out_valid_d  = m_axis_tvalid;
        out_last_d   = m_axis_tlast;
        busy_d       = busy;
        fcount_d     = frame_count;
        blk_we       = 1'b0;
        close        = 1'b0;
        close_n      = run_n;
        close_after  = AFT_FILL;
        next_block   = 1'b0;
        nxt_idx      = idx + NW'(1);

        // Empty non-last words carry nothing, so they are dropped at acceptance.
        if (in_fire) begin
            word_data_d  = s_axis_tdata;
            word_keep_d  = s_axis_tkeep;
            word_last_d  = s_axis_tlast;
            word_valid_d = s_axis_tlast || (s_axis_tkeep != '0);
            busy_d       = 1'b1;
        end
        if (out_fire && m_axis_tlast) begin
            fcount_d = frame_count + 16'd1;
            busy_d   = 1'b0;
        end

        unique case (state)
            FILL: begin
                if (word_valid) begin
                    if (word_keep == '0) begin
                        // Empty tlast word closes whatever block is open.
                        word_valid_d = 1'b0;
                        close        = 1'b1;
                        close_after  = AFT_DELIM;
                    end else begin
                        word_keep_d  = keep_rem;
                        word_valid_d = (keep_rem != '0);
                        if (cur_byte == 8'h00) begin
                            close       = 1'b1;
                            close_after = byte_last ? AFT_CODE1 : AFT_FILL;
                        end else begin
                            blk_we  = 1'b1;
                            close_n = run_n + NW'(1);
                            run_n_d = close_n;
                            if (close_n == NW'(MAX_RUN)) begin
                                close       = 1'b1;
                                close_after = byte_last ? AFT_DELIM : AFT_FILL;
                            end else if (byte_last) begin
                                close       = 1'b1;
                                close_after = AFT_DELIM;
                            end
                        end
                    end
                    if (close) begin
                        state_d     = EMIT_CODE;
                        after_d     = close_after;
                        out_valid_d = 1'b1;
                        out_data_d  = 8'(close_n) + 8'd1;
                        out_last_d  = !APPEND_DELIMITER && (close_after == AFT_DELIM)
                                      && (close_n == '0);
                    end
                end
            end
            EMIT_CODE: begin
                if (out_fire) begin
                    if (run_n != '0) begin
                        state_d    = EMIT_DATA;
                        idx_d      = '0;
                        out_data_d = blk_mem[0];
                        out_last_d = !APPEND_DELIMITER && (after == AFT_DELIM)
                                     && (run_n == NW'(1));
                    end else begin
                        next_block = 1'b1;
                    end
                end
            end
            EMIT_DATA: begin
                if (out_fire) begin
                    if (idx == run_n - NW'(1)) begin
                        next_block = 1'b1;
                    end else begin
                        idx_d      = nxt_idx;
                        out_data_d = blk_mem[nxt_idx];
                        out_last_d = !APPEND_DELIMITER && (after == AFT_DELIM)
                                     && (nxt_idx + NW'(1) == run_n);
                    end
                end
            end
            DELIM: begin
                if (out_fire) begin
                    state_d     = FILL;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    out_data_d  = 8'h00;
                end
            end
        endcase

        // Block fully sent: clear the run and move on.
        if (next_block) begin
            run_n_d = '0;
            case (after)
                AFT_CODE1: begin
                    // Frame ended on a zero: one more empty block (code 0x01).
                    state_d     = EMIT_CODE;
                    after_d     = AFT_DELIM;
                    out_valid_d = 1'b1;
                    out_data_d  = 8'h01;
                    out_last_d  = !APPEND_DELIMITER;
                end
                AFT_DELIM: begin
                    if (APPEND_DELIMITER) begin
                        state_d     = DELIM;
                        out_valid_d = 1'b1;
                        out_data_d  = 8'h00;
                        out_last_d  = 1'b1;
                    end else begin
                        state_d     = FILL;
                        out_valid_d = 1'b0;
                        out_data_d  = 8'h00;
                        out_last_d  = 1'b0;
                    end
                end
                default: begin
                    state_d     = FILL;
                    out_valid_d = 1'b0;
                    out_data_d  = 8'h00;
                    out_last_d  = 1'b0;
                end
            endcase
        end

        tready_d = (state_d == FILL) && !word_valid_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= FILL;
            after         <= AFT_FILL;
            word_data     <= '0;
            word_keep     <= '0;
            word_last     <= 1'b0;
            word_valid    <= 1'b0;
            run_n         <= '0;
            idx           <= '0;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            s_axis_tready <= 1'b0;
            busy          <= 1'b0;
            frame_count   <= 16'h0000;
        end else begin
            state         <= state_d;
            after         <= after_d;
            word_data     <= word_data_d;
            word_keep     <= word_keep_d;
            word_last     <= word_last_d;
            word_valid    <= word_valid_d;
            run_n         <= run_n_d;
            idx           <= idx_d;
            m_axis_tdata  <= out_data_d;
            m_axis_tvalid <= out_valid_d;
            m_axis_tlast  <= out_last_d;
            s_axis_tready <= tready_d;
            busy          <= busy_d;
            frame_count   <= fcount_d;
        end
    end

    // Block buffer; contents are only meaningful below run_n.
    always_ff @(posedge clk) begin
        if (blk_we) blk_mem[run_n] <= cur_byte;
    end

endmodule
